fire5_expand3_ofm_writer: RTL and testbench

Downstream drain stage for the fire5 expand-3x3 layer. It captures the `DSP_NO`-wide parallel ofm vector on each sample pulse and writes it word by word into the layer output RAM in channel-planar order. It drives `ram_feedback`, so the upstream layer only reports finish after the last pixel has been written. It also counts pixels and flags dropped vectors.

---
 rtl/fire5_expand3_ofm_writer.sv | 150 +++++++++++++++
 tb/tb_fire5_expand3_ofm_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fire5_expand3_ofm_writer.sv
// Drains one captured DSP_NO-wide ofm vector per sample into the channel-planar output RAM.
// Optional running checksum of written words is enabled by defining FIRE5_WR_CHECKSUM_EN.
module fire5_expand3_ofm_writer #(
  parameter int DSP_NO = 128,
  parameter int WIDTH  = 16,
  parameter int WOUT   = 128,
  parameter int AW     = $clog2(DSP_NO * WOUT * WOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ofm_sample,
  input  logic [WIDTH-1:0] ofm [DSP_NO],
  output logic             ram_feedback,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             layer_done,
  output logic             overrun_err,
  output logic [31:0]      checksum
);

  localparam int PIX     = WOUT * WOUT;
  localparam int CHW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PW      = $clog2(PIX) + 1;
  localparam bit PIX_POW2 = ((PIX & (PIX - 1)) == 0);

  localparam logic [CHW-1:0] CH_LAST  = CHW'(DSP_NO - 1);
  localparam logic [PW-1:0]  PIX_LAST = PW'(PIX - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CHW-1:0]   ch_r;
  logic [PW-1:0]    pix_r;
  logic [WIDTH-1:0] shadow_r [DSP_NO];
  logic [AW-1:0]    base_s;
  logic             drain_s;
  logic             last_ch_s;
  logic             capture_s;

  logic             wr_en_r;
  logic [AW-1:0]    wr_addr_r;
  logic [WIDTH-1:0] wr_data_r;
  logic             ram_feedback_r;
  logic             layer_done_r;
  logic             overrun_r;

  assign drain_s   = (state_r == DRAIN);
  assign last_ch_s = (ch_r == CH_LAST);
  assign capture_s = (state_r == IDLE) && ofm_sample;

  // Next-state logic for the IDLE/DRAIN/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ofm_sample) state_s = DRAIN;
        else            state_s = IDLE;
      end
      DRAIN: begin
        if (last_ch_s) state_s = (pix_r == PIX_LAST) ? DONE : IDLE;
        else           state_s = DRAIN;
      end
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Channel-plane base address: a shift for power-of-two planes, otherwise a running sum.
  generate
    if (PIX_POW2) begin : g_base_shift
      assign base_s = AW'(ch_r) << $clog2(PIX);
    end else begin : g_base_acc
      logic [AW-1:0] base_r;
      // Advance the plane base one plane per drained channel, back to 0 after the last.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                       base_r <= {AW{1'b0}};
        else if (drain_s && last_ch_s) base_r <= {AW{1'b0}};
        else if (drain_s)              base_r <= base_r + AW'(PIX);
        else                           base_r <= base_r;
      end
      assign base_s = base_r;
    end
  endgenerate

  // Shadow buffer holds the vector being drained; no reset needed, every drain reloads it.
  always_ff @(posedge clk) begin
    if (capture_s) shadow_r <= ofm;
  end

  // Sequencer state, counters and registered RAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      ch_r           <= {CHW{1'b0}};
      pix_r          <= {PW{1'b0}};
      wr_en_r        <= 1'b0;
      wr_addr_r      <= {AW{1'b0}};
      wr_data_r      <= {WIDTH{1'b0}};
      ram_feedback_r <= 1'b0;
      layer_done_r   <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      wr_en_r        <= drain_s;
      // Busy covers the drain plus the cycle in which the last write is on the bus.
      ram_feedback_r <= drain_s || (state_s == DRAIN);
      layer_done_r   <= layer_done_r || (state_r == DONE);
      overrun_r      <= overrun_r || (drain_s && ofm_sample);
      if (drain_s) begin
        wr_addr_r <= base_s + AW'(pix_r);
        wr_data_r <= shadow_r[ch_r];
      end
      if (capture_s) begin
        ch_r <= {CHW{1'b0}};
      end else if (drain_s) begin
        if (last_ch_s) begin
          ch_r  <= {CHW{1'b0}};
          pix_r <= pix_r + PW'(1);
        end else begin
          ch_r <= ch_r + CHW'(1);
        end
      end
    end
  end

`ifdef FIRE5_WR_CHECKSUM_EN
  logic [31:0] checksum_r;
  // Running modulo-2^32 sum of every word committed to the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          checksum_r <= 32'd0;
    else if (wr_en_r) checksum_r <= checksum_r + 32'(wr_data_r);
    else              checksum_r <= checksum_r;
  end
  assign checksum = checksum_r;
`else
  assign checksum = 32'd0;
`endif

  assign ram_feedback = ram_feedback_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign layer_done   = layer_done_r;
  assign overrun_err  = overrun_r;

endmodule

// File: tb/tb_fire5_expand3_ofm_writer.sv
// Bench for fire5_expand3_ofm_writer (DSP_NO=4, WOUT=2): per-cycle compare against a
// transaction-level expectation table, plus hand-computed literal checks.
module tb_fire5_expand3_ofm_writer;
  localparam int DSP_NO = 4;
  localparam int WIDTH  = 16;
  localparam int WOUT   = 2;
  localparam int PIX    = WOUT * WOUT;
  localparam int AW     = 4;
  localparam int NCYC   = 512;
  localparam int NEVER  = 1 << 30;
`ifdef FIRE5_WR_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             ofm_sample;
  logic [WIDTH-1:0] ofm [DSP_NO];
  logic             ram_feedback, wr_en, layer_done, overrun_err;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [31:0]      checksum;

  fire5_expand3_ofm_writer #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ofm_sample(ofm_sample), .ofm(ofm),
    .ram_feedback(ram_feedback), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .layer_done(layer_done), .overrun_err(overrun_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // cyc = index of the last rising edge; expectation arrays are indexed by "value after edge c".
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit               exp_we   [NCYC];
  bit               exp_fb   [NCYC];
  logic [AW-1:0]    exp_addr [NCYC];
  logic [WIDTH-1:0] exp_data [NCYC];
  int ovr_from    = NEVER;
  int done_from   = NEVER;
  int pix_m       = 0;
  int next_accept = 0;
  int checks      = 0;
  int errors      = 0;
  int seen [16];
  logic [31:0] cks_m = 32'd0;
  bit comparing = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the expectation table, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (comparing) begin
        if (rst) begin
          cks_m = 32'd0;
          for (int i = 0; i < 16; i++) seen[i] = 0;
        end else if (exp_we[cyc-1]) begin
          cks_m = cks_m + 32'(exp_data[cyc-1]);
        end
        chk("wr_en", 32'(wr_en), 32'(exp_we[cyc]));
        if (exp_we[cyc]) begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_addr[cyc]));
          chk("wr_data", 32'(wr_data), 32'(exp_data[cyc]));
        end
        chk("ram_feedback", 32'(ram_feedback), 32'(exp_fb[cyc]));
        chk("layer_done", 32'(layer_done), 32'(cyc >= done_from));
        chk("overrun_err", 32'(overrun_err), 32'(cyc >= ovr_from));
        chk("checksum", checksum, CKS_EN ? cks_m : 32'd0);
        if (wr_en && !rst) seen[wr_addr] = seen[wr_addr] + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Issue one sample; the model decides accept / overrun / ignore from the spec's timing rules.
  task automatic sample(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v [DSP_NO];
    int e0;
    v = '{a, b, c, d};
    e0 = cyc + 1;
    ofm = v;
    ofm_sample = 1'b1;
    if (e0 < next_accept) begin
      if (ovr_from > e0) ovr_from = e0;
    end else if (pix_m < PIX) begin
      for (int k = 0; k < DSP_NO; k++) begin
        exp_we[e0+1+k]   = 1'b1;
        exp_addr[e0+1+k] = AW'(k * PIX + pix_m);
        exp_data[e0+1+k] = v[k];
      end
      for (int t = e0; t <= e0 + DSP_NO; t++) exp_fb[t] = 1'b1;
      next_accept = e0 + DSP_NO + 1;
      pix_m++;
      if (pix_m == PIX) done_from = e0 + DSP_NO + 1;
    end
    step(1);
    ofm_sample = 1'b0;
  endtask

  task automatic do_reset();
    int k;
    k = cyc;
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_feedback", 32'(ram_feedback), 32'd0);
    chk("rst_done", 32'(layer_done), 32'd0);
    chk("rst_overrun", 32'(overrun_err), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    for (int i = k; i < NCYC; i++) begin
      exp_we[i] = 1'b0;
      exp_fb[i] = 1'b0;
    end
    pix_m = 0;
    next_accept = 0;
    ovr_from = NEVER;
    done_from = NEVER;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int la [4] = '{0, 4, 8, 12};

  initial begin
    rst = 1'b1;
    ofm_sample = 1'b0;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = 16'd0;
    for (int i = 0; i < NCYC; i++) begin
      exp_we[i] = 1'b0;
      exp_fb[i] = 1'b0;
      exp_addr[i] = 4'd0;
      exp_data[i] = 16'd0;
    end
    for (int i = 0; i < 16; i++) seen[i] = 0;
    step(2);
    rst = 1'b0;
    chk("init_feedback", 32'(ram_feedback), 32'd0);
    chk("init_wr_en", 32'(wr_en), 32'd0);
    comparing = 1'b1;

    // Single vector {1,2,3,4}: writes (0,1),(4,2),(8,3),(12,4), busy ends after E5.
    sample(16'd1, 16'd2, 16'd3, 16'd4);
    chk("single_fb_E0", 32'(ram_feedback), 32'd1);
    for (int k = 0; k < DSP_NO; k++) begin
      step(1);
      chk("single_we", 32'(wr_en), 32'd1);
      chk("single_addr", 32'(wr_addr), 32'(la[k]));
      chk("single_data", 32'(wr_data), 32'(k + 1));
    end
    step(1);
    chk("single_fb_after_E5", 32'(ram_feedback), 32'd0);
    step(3);

    // Overrun: second sample two cycles after the first is dropped.
    do_reset();
    step(1);
    sample(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    step(1);
    sample(16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d);
    step(6);
    chk("overrun_set", 32'(overrun_err), 32'd1);
    sample(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    step(1);
    chk("overrun_next_pix_addr", 32'(wr_addr), 32'd1);
    chk("overrun_next_pix_data", 32'(wr_data), 32'h0101);
    step(6);

    // Back-to-back at E5 accepted; a sample in the final drain cycle overruns.
    do_reset();
    step(1);
    sample(16'h1000, 16'h1001, 16'h1002, 16'h1003);
    step(4);
    sample(16'h2000, 16'h2001, 16'h2002, 16'h2003);
    chk("b2b_gap_we", 32'(wr_en), 32'd0);
    chk("b2b_no_overrun", 32'(overrun_err), 32'd0);
    step(3);
    sample(16'h3000, 16'h3001, 16'h3002, 16'h3003);
    step(2);
    chk("final_cycle_overrun", 32'(overrun_err), 32'd1);
    step(4);

    // Reset after E2, then a fresh sample writes ch0 at pix0.
    do_reset();
    step(1);
    sample(16'h4444, 16'h5555, 16'h6666, 16'h7777);
    step(2);
    do_reset();
    step(1);
    sample(16'h0abc, 16'h0def, 16'h0123, 16'h0456);
    step(1);
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_data", 32'(wr_data), 32'h0abc);
    step(6);

    // Full layer of 0x7FFF words, samples 10 cycles apart.
    do_reset();
    step(1);
    for (int p = 0; p < PIX; p++) begin
      sample(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
      step(9);
    end
    chk("layer_done", 32'(layer_done), 32'd1);
    chk("layer_fb", 32'(ram_feedback), 32'd0);
    chk("layer_checksum", checksum, CKS_EN ? 32'h0007fff0 : 32'd0);
    for (int a = 0; a < 16; a++) chk("addr_once", 32'(seen[a]), 32'd1);
    sample(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    step(6);
    chk("done_ignores_overrun", 32'(overrun_err), 32'd0);
    chk("done_no_write", 32'(wr_en), 32'd0);
    chk("done_holds", 32'(layer_done), 32'd1);

    comparing = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
